// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan engine: FSM state codes, default panel
// geometry, and helpers that derive field widths from that geometry.
package hub75_pkg;

  localparam int DEF_HPIXEL   = 64;
  localparam int DEF_VPIXEL   = 64;
  localparam int DEF_BPP      = 8;
  localparam int DEF_SEGMENTS = 2;
  localparam int DEF_BASE_OE  = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SHIFT   = 2'd1;
  localparam state_t ST_LATCH   = 2'd2;
  localparam state_t ST_DISPLAY = 2'd3;

  function automatic int col_bits(input int hpixel);
    return $clog2(hpixel);
  endfunction

  function automatic int row_bits(input int vpixel, input int segments);
    return $clog2(vpixel / segments);
  endfunction

  function automatic int addr_bits(input int hpixel, input int vpixel);
    return $clog2(hpixel * vpixel);
  endfunction

  // A single-plane panel still needs a 1-bit plane register
  function automatic int plane_bits(input int bpp);
    return (bpp > 1) ? $clog2(bpp) : 1;
  endfunction

  function automatic int oe_cnt_bits(input int base_oe, input int bpp);
    return $clog2(base_oe << (bpp - 1)) + 1;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-weighted display timer: loaded with BASE_OE << plane, counts down while
// running and flags the final display cycle.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BASE_OE = DEF_BASE_OE,
  parameter int BPP     = DEF_BPP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic [plane_bits(BPP)-1:0] i_plane,
  input  logic                       i_run,
  output logic                       o_done
);

  localparam int OW = oe_cnt_bits(BASE_OE, BPP);

  logic [OW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= OW'(BASE_OE) << i_plane;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - OW'(1);
    end
  end

  // Done on the last cycle so the caller can release OE exactly on time
  assign o_done = i_run && (r_count == OW'(1));

endmodule

// File: rtl/hub75_scan.sv
// HUB75 scan engine: fetches a row of pixels per bit plane, shifts one bit per
// segment/colour into the panel, latches it and shows it for a BCM-weighted time.
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int HPIXEL   = DEF_HPIXEL,
  parameter int VPIXEL   = DEF_VPIXEL,
  parameter int BPP      = DEF_BPP,
  parameter int SEGMENTS = DEF_SEGMENTS,
  parameter int BASE_OE  = DEF_BASE_OE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_en,
  output logic [addr_bits(HPIXEL, VPIXEL)-1:0]   o_rd_addr,
  input  logic [SEGMENTS*3*BPP-1:0]              i_rd_data,
  output logic                                   o_hub_clk,
  output logic                                   o_hub_lat,
  output logic                                   o_hub_oe_n,
  output logic [row_bits(VPIXEL, SEGMENTS)-1:0]  o_hub_addr,
  output logic [SEGMENTS*3-1:0]                  o_hub_rgb,
  output logic                                   o_frame_start
);

  localparam int CB   = col_bits(HPIXEL);
  localparam int RB   = row_bits(VPIXEL, SEGMENTS);
  localparam int AW   = addr_bits(HPIXEL, VPIXEL);
  localparam int PB   = plane_bits(BPP);
  localparam int TW   = CB + 2;
  localparam int ROWS = VPIXEL / SEGMENTS;

  localparam logic [TW-1:0] T_LAST      = TW'(2 * HPIXEL + 1);
  localparam logic [TW-1:0] T_LAST_DATA = TW'(2 * HPIXEL - 1);
  localparam logic [RB-1:0] ROW_LAST    = RB'(ROWS - 1);
  localparam logic [PB-1:0] PLANE_LAST  = PB'(BPP - 1);

  state_t               r_state;
  logic [TW-1:0]        r_tcnt;
  logic [RB-1:0]        r_row;
  logic [PB-1:0]        r_plane;
  logic [AW-1:0]        r_rd_addr;
  logic                 r_hub_clk;
  logic                 r_hub_lat;
  logic                 r_hub_oe_n;
  logic [RB-1:0]        r_hub_addr;
  logic [SEGMENTS*3-1:0] r_hub_rgb;
  logic                 r_frame_start;

  logic [TW-1:0]        w_tnext;
  logic [CB-1:0]        w_next_col;
  logic [AW-1:0]        w_shift_addr;
  logic                 w_plane_wrap;
  logic                 w_row_wrap;
  logic [RB-1:0]        w_next_row;
  logic [PB-1:0]        w_next_plane;
  logic [AW-1:0]        w_row_start_addr;
  logic [SEGMENTS*3-1:0] w_plane_bits;
  logic                 w_oe_done;

  // Odd shift slots fetch column (t+1)/2, so the column is the upper bits of t+1
  assign w_tnext      = r_tcnt + TW'(1);
  assign w_next_col   = w_tnext[CB:1];
  assign w_shift_addr = AW'({r_row, w_next_col});

  assign w_plane_wrap     = (r_plane == PLANE_LAST);
  assign w_row_wrap       = (r_row == ROW_LAST);
  assign w_next_plane     = w_plane_wrap ? '0 : r_plane + PB'(1);
  assign w_next_row       = !w_plane_wrap ? r_row : (w_row_wrap ? '0 : r_row + RB'(1));
  assign w_row_start_addr = AW'({w_next_row, {CB{1'b0}}});

  always_comb begin
    logic [BPP-1:0] v_chan;
    v_chan       = '0;
    w_plane_bits = '0;
    for (int i = 0; i < SEGMENTS * 3; i++) begin
      v_chan          = i_rd_data[i*BPP +: BPP];
      w_plane_bits[i] = v_chan[r_plane];
    end
  end

  hub75_bcm_timer #(
    .BASE_OE (BASE_OE),
    .BPP     (BPP)
  ) u_bcm_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (r_state == ST_LATCH),
    .i_plane (r_plane),
    .i_run   (r_state == ST_DISPLAY),
    .o_done  (w_oe_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tcnt        <= '0;
      r_row         <= '0;
      r_plane       <= '0;
      r_rd_addr     <= '0;
      r_hub_clk     <= 1'b0;
      r_hub_lat     <= 1'b0;
      r_hub_oe_n    <= 1'b1;
      r_hub_addr    <= '0;
      r_hub_rgb     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_hub_oe_n <= 1'b1;
          r_hub_clk  <= 1'b0;
          r_hub_lat  <= 1'b0;
          if (i_en) begin
            r_state       <= ST_SHIFT;
            r_row         <= '0;
            r_plane       <= '0;
            r_tcnt        <= '0;
            r_rd_addr     <= '0;
            r_frame_start <= 1'b1;
          end
        end

        // Even slots raise the panel clock, odd slots capture data and drop it
        ST_SHIFT: begin
          if (r_tcnt == T_LAST) begin
            r_state    <= ST_LATCH;
            r_tcnt     <= '0;
            r_hub_clk  <= 1'b0;
            r_hub_lat  <= 1'b1;
            r_hub_addr <= r_row;
          end else begin
            r_tcnt <= w_tnext;
            if (r_tcnt[0]) begin
              r_hub_clk <= 1'b0;
              r_hub_rgb <= w_plane_bits;
              if (r_tcnt < T_LAST_DATA) begin
                r_rd_addr <= w_shift_addr;
              end
            end else begin
              r_hub_clk <= (r_tcnt != '0);
            end
          end
        end

        ST_LATCH: begin
          r_hub_lat  <= 1'b0;
          r_hub_oe_n <= 1'b0;
          r_state    <= ST_DISPLAY;
        end

        ST_DISPLAY: begin
          if (w_oe_done) begin
            r_hub_oe_n <= 1'b1;
            if (!i_en) begin
              r_state <= ST_IDLE;
            end else begin
              r_state       <= ST_SHIFT;
              r_tcnt        <= '0;
              r_plane       <= w_next_plane;
              r_row         <= w_next_row;
              r_rd_addr     <= w_row_start_addr;
              r_frame_start <= w_plane_wrap && w_row_wrap;
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_hub_oe_n <= 1'b1;
        end
      endcase
    end
  end

  assign o_rd_addr     = r_rd_addr;
  assign o_hub_clk     = r_hub_clk;
  assign o_hub_lat     = r_hub_lat;
  assign o_hub_oe_n    = r_hub_oe_n;
  assign o_hub_addr    = r_hub_addr;
  assign o_hub_rgb     = r_hub_rgb;
  assign o_frame_start = r_frame_start;

endmodule
